// File: rtl/icache_pkg.sv
// Shared geometry and FSM state type for the direct-mapped instruction cache.
// 16-byte lines of 4 words, 64 lines, 22-bit tags.
package icache_pkg;

    localparam int OFFSET_W   = 4;
    localparam int INDEX_W    = 6;
    localparam int TAG_W      = 22;
    localparam int WORD_SEL_W = OFFSET_W - 2;
    localparam int BASE_W     = 32 - OFFSET_W;
    localparam int LINE_WORDS = 4;
    localparam int NUM_LINES  = 64;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache. Reads are asynchronous.
// Writes go in one word per cycle. Valid bits can be cleared all at once.
module icache_array
    import icache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_W-1:0]    rd_idx,
    input  logic [WORD_SEL_W-1:0] rd_word,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_W-1:0]    wr_idx,
    input  logic [WORD_SEL_W-1:0] wr_word,
    input  logic [31:0]           wr_data,
    input  logic                  tag_we,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic                  clear_all
);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [31:0]          data_mem [NUM_LINES][LINE_WORDS];

    // Clearing takes priority, so a fence that lands on the final refill
    // word leaves the line invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (clear_all) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_idx][wr_word] <= wr_data;
        end
        if (tag_we) begin
            tag_mem[wr_idx] <= wr_tag;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx][rd_word];

endmodule

// File: rtl/inst_cache.sv
// Read-only direct-mapped instruction cache. It has a 0-cycle hit path and
// refills 4-word lines over the bus. Define ICACHE_PERF_EN to add the hit and miss counters.
module inst_cache
    import icache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_in,
    output logic        inst_valid,
    output logic [31:0] addr_o,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        we_o,
    output logic        rd_o,
    input  logic        ack_i,
    input  logic        fence
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    state_t                state_q, state_d;
    logic [BASE_W-1:0]     base_q;
    logic [WORD_SEL_W-1:0] cnt_q;
    logic                  fence_pending_q;

    logic                  arr_valid;
    logic [TAG_W-1:0]      arr_tag;
    logic [31:0]           arr_data;
    logic                  hit;
    logic                  start_fill;
    logic                  wr_en;
    logic                  tag_we;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^inst_addr[1:0];

    icache_array u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (inst_addr[OFFSET_W+INDEX_W-1:OFFSET_W]),
        .rd_word   (inst_addr[OFFSET_W-1:2]),
        .rd_valid  (arr_valid),
        .rd_tag    (arr_tag),
        .rd_data   (arr_data),
        .wr_en     (wr_en),
        .wr_idx    (base_q[INDEX_W-1:0]),
        .wr_word   (cnt_q),
        .wr_data   (data_i),
        .tag_we    (tag_we),
        .wr_tag    (base_q[BASE_W-1:INDEX_W]),
        .clear_all (fence)
    );

    assign hit    = arr_valid && (arr_tag == inst_addr[31:OFFSET_W+INDEX_W]);
    assign data_o = '0;
    assign we_o   = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Hit data is gated to zero so that inst_in reads 0 whenever inst_valid is low.
    always_comb begin
        state_d    = state_q;
        rd_o       = 1'b0;
        addr_o     = '0;
        inst_valid = 1'b0;
        inst_in    = '0;
        wr_en      = 1'b0;
        tag_we     = 1'b0;
        start_fill = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    inst_valid = 1'b1;
                    inst_in    = arr_data;
                end else begin
                    start_fill = 1'b1;
                    state_d    = FILL;
                end
            end
            FILL: begin
                rd_o   = 1'b1;
                addr_o = {base_q, cnt_q, 2'b00};
                if (ack_i) begin
                    wr_en = 1'b1;
                    if (cnt_q == WORD_SEL_W'(LINE_WORDS - 1)) begin
                        tag_we  = !fence_pending_q && !fence;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A fence seen during a refill lets the bus transfer finish and keeps the line invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q          <= '0;
            cnt_q           <= '0;
            fence_pending_q <= 1'b0;
        end else if (start_fill) begin
            base_q          <= inst_addr[31:OFFSET_W];
            cnt_q           <= '0;
            fence_pending_q <= 1'b0;
        end else if (state_q == FILL) begin
            if (ack_i) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_d == IDLE) begin
                fence_pending_q <= 1'b0;
            end else if (fence) begin
                fence_pending_q <= 1'b1;
            end
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] prev_addr_q;

    // A hit counts only when the fetch address moves, so stalled fetches are not counted twice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count   <= '0;
            miss_count  <= '0;
            prev_addr_q <= '0;
        end else begin
            prev_addr_q <= inst_addr;
            if (inst_valid && (inst_addr != prev_addr_q)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_fill) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed testbench for inst_cache. The bus responder acks about 3 cycles
// after each request and returns data_i = addr_o. A scoreboard checks the bus and fetch results.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] data_i = '0;
    logic        ack_i = 1'b0;
    logic        fence = 1'b0;
    logic [31:0] inst_in;
    logic        inst_valid;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic        we_o;
    logic        rd_o;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] busQ[$];
    logic [31:0] instQ[$];

    inst_cache dut (
        .clk        (clk),
        .rst        (rst),
        .inst_addr  (inst_addr),
        .inst_in    (inst_in),
        .inst_valid (inst_valid),
        .addr_o     (addr_o),
        .data_i     (data_i),
        .data_o     (data_o),
        .we_o       (we_o),
        .rd_o       (rd_o),
        .ack_i      (ack_i),
        .fence      (fence)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr);
        @(negedge clk);
        inst_addr = addr;
        #1;
    endtask

    task automatic pushLine(input logic [31:0] addr);
        logic [31:0] base;
        base = {addr[31:4], 4'h0};
        for (int w = 0; w < 4; w++) begin
            busQ.push_back(base + 32'(w * 4));
        end
    endtask

    // Expected penalty from IDLE is 16 negedges: 4 words x 4-cycle bus turnaround.
    task automatic waitFill(input logic [31:0] addr, input int expCycles);
        int cycles;
        cycles = 0;
        while (!inst_valid && cycles < 200) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        checkOutput($sformatf("fill_done@%h", addr), 32'(inst_valid), 32'd1);
        checkOutput($sformatf("fill_data@%h", addr), inst_in, instQ.pop_front());
        checkOutput($sformatf("fill_words@%h", addr), 32'(busQ.size()), 32'd0);
        checkOutput($sformatf("fill_rd_low@%h", addr), 32'(rd_o), 32'd0);
        if (expCycles >= 0) begin
            checkOutput($sformatf("miss_penalty@%h", addr), 32'(cycles), 32'(expCycles));
        end
    endtask

    task automatic fetchMiss(input logic [31:0] addr, input int expCycles);
        pushLine(addr);
        instQ.push_back({addr[31:2], 2'b00});
        applyStimulus(addr);
        checkOutput($sformatf("miss_valid_low@%h", addr), 32'(inst_valid), 32'd0);
        waitFill(addr, expCycles);
    endtask

    task automatic fetchHit(input logic [31:0] addr);
        instQ.push_back({addr[31:2], 2'b00});
        applyStimulus(addr);
        checkOutput($sformatf("hit_valid@%h", addr), 32'(inst_valid), 32'd1);
        checkOutput($sformatf("hit_data@%h", addr), inst_in, instQ.pop_front());
        checkOutput($sformatf("hit_no_read@%h", addr), 32'(rd_o), 32'd0);
        @(negedge clk);
        #1;
        checkOutput($sformatf("hit_stays_idle@%h", addr), 32'(rd_o), 32'd0);
    endtask

    // Bus responder: acks the third negedge of a request, then idles one cycle.
    initial begin : bus_model
        int lat;
        lat = 0;
        forever begin
            @(negedge clk);
            if (!rst || !rd_o || ack_i) begin
                ack_i = 1'b0;
                lat   = 0;
            end else if (lat == 2) begin
                ack_i  = 1'b1;
                data_i = addr_o;
                lat    = 0;
                checkOutput("bus_read_expected", 32'(busQ.size() != 0), 32'd1);
                if (busQ.size() != 0) begin
                    checkOutput("bus_addr_order", addr_o, busQ.pop_front());
                end
            end else begin
                lat++;
            end
        end
    end

    initial begin : stimulus
        int cycles;

        $display("[TB] reset state");
        #12;
        checkOutput("reset_rd_o", 32'(rd_o), 32'd0);
        checkOutput("reset_addr_o", addr_o, 32'd0);
        checkOutput("reset_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("reset_inst_in", inst_in, 32'd0);
        checkOutput("data_o_tied", data_o, 32'd0);
        checkOutput("we_o_tied", 32'(we_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] cold miss and line hits");
        fetchMiss(32'h000, -1);
        fetchHit(32'h004);
        fetchHit(32'h008);
        fetchHit(32'h00C);

        $display("[TB] next line");
        fetchMiss(32'h010, 16);
        fetchHit(32'h014);
        fetchHit(32'h018);
        fetchHit(32'h01C);

        $display("[TB] distinct index");
        fetchMiss(32'h130, 16);
        fetchHit(32'h134);
        fetchHit(32'h13C);
        fetchHit(32'h004);

        $display("[TB] conflict");
        fetchMiss(32'h400, 16);
        fetchMiss(32'h004, 16);

        $display("[TB] fence in IDLE");
        @(negedge clk);
        inst_addr = 32'h000;
        fence     = 1'b1;
        pushLine(32'h000);
        instQ.push_back(32'h000);
        @(negedge clk);
        fence = 1'b0;
        #1;
        checkOutput("fence_invalidates", 32'(inst_valid), 32'd0);
        waitFill(32'h000, 16);

        $display("[TB] fence during FILL");
        pushLine(32'h020);
        applyStimulus(32'h020);
        repeat (5) @(negedge clk);
        fence = 1'b1;
        @(negedge clk);
        fence = 1'b0;
        cycles = 0;
        while (rd_o && cycles < 200) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        checkOutput("fence_fill_finishes", 32'(rd_o), 32'd0);
        checkOutput("fence_fill_words", 32'(busQ.size()), 32'd0);
        checkOutput("fence_fill_not_valid", 32'(inst_valid), 32'd0);
        pushLine(32'h020);
        instQ.push_back(32'h020);
        waitFill(32'h020, 16);
        fetchMiss(32'h004, 16);

        $display("[TB] reset during FILL");
        pushLine(32'h030);
        applyStimulus(32'h030);
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midfill_reset_rd_o", 32'(rd_o), 32'd0);
        checkOutput("midfill_reset_valid", 32'(inst_valid), 32'd0);
        checkOutput("midfill_reset_addr_o", addr_o, 32'd0);
        busQ.delete();
        @(negedge clk);
        rst = 1'b1;
        fetchMiss(32'h030, -1);
        fetchMiss(32'h000, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
